// File: rtl/sobel_fifo_frame_reader_if.sv
// Handshake bundle between the sobel prefetch FIFO read port, the frame
// reader and the downstream Sobel datapath stream.
interface sobel_fifo_frame_reader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_vld;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sol;
  logic              out_eol;
  logic              out_sof;
  logic              out_eof;

  // Frame reader side: pops the FIFO and drives the pixel stream.
  modport master (
    input  fifo_rd_data, fifo_rd_vld, out_ready,
    output fifo_rd_en, out_data, out_valid, out_sol, out_eol, out_sof, out_eof
  );

  // Environment side: FIFO read port plus the stream consumer.
  modport slave (
    output fifo_rd_data, fifo_rd_vld, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_sol, out_eol, out_sof, out_eof
  );
endinterface

// File: rtl/sobel_fifo_frame_reader.sv
// Sobel frame reader: drains a first-word-fall-through FIFO into a
// valid/ready pixel stream tagged with line/frame markers, with optional
// idle gaps between lines, frame-done pulse and starvation counting.
module sobel_fifo_frame_reader #(
  parameter int DATA_W   = 32,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LINE_GAP = 0,
  parameter int CNT_W    = 12
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst,
  input  logic                       start,
  sobel_fifo_frame_reader_if.master  bus,
  output logic                       busy,
  output logic                       frame_done,
  output logic [15:0]                starve_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_ACTIVE - 1);
  localparam logic [15:0]      GAP_LOAD = 16'((LINE_GAP > 0) ? (LINE_GAP - 1) : 0);

  state_t            state;
  logic [CNT_W-1:0]  x;
  logic [CNT_W-1:0]  y;
  logic [15:0]       gap_cnt;

  logic [DATA_W-1:0] pix_s;
  logic              slot_free_s;
  logic              pop_s;
  logic              last_x_s;
  logic              last_y_s;

  assign pix_s       = bus.fifo_rd_data;
  // The output register can take a new word when empty or emptying now.
  assign slot_free_s = ~bus.out_valid | bus.out_ready;
  assign bus.fifo_rd_en = (state == RUN) & slot_free_s;
  assign pop_s       = bus.fifo_rd_vld & bus.fifo_rd_en;
  assign last_x_s    = (x == X_LAST);
  assign last_y_s    = (y == Y_LAST);

  // Output register, pixel/line counters, gap timer and frame FSM.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state         <= IDLE;
      x             <= '0;
      y             <= '0;
      gap_cnt       <= 16'd0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sol   <= 1'b0;
      bus.out_eol   <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_eof   <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      starve_cnt    <= 16'd0;
    end else begin
      frame_done <= 1'b0;

      // Pop reloads the stage; a transfer without a pop empties it.
      if (pop_s) begin
        bus.out_data  <= pix_s;
        bus.out_valid <= 1'b1;
        bus.out_sol   <= (x == '0);
        bus.out_eol   <= last_x_s;
        bus.out_sof   <= (x == '0) & (y == '0);
        bus.out_eof   <= last_x_s & last_y_s;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // A start landing on the frame_done cycle belongs to the old frame.
          if (start & ~frame_done) begin
            state      <= RUN;
            x          <= '0;
            y          <= '0;
            starve_cnt <= 16'd0;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (slot_free_s & ~bus.fifo_rd_vld & (starve_cnt != 16'hFFFF)) begin
            starve_cnt <= starve_cnt + 16'd1;
          end
          if (pop_s) begin
            if (last_x_s) begin
              x <= '0;
              if (last_y_s) begin
                y     <= '0;
                state <= DRAIN;
              end else begin
                y <= y + CNT_W'(1);
                if (LINE_GAP > 0) begin
                  state   <= GAP;
                  gap_cnt <= GAP_LOAD;
                end
              end
            end else begin
              x <= x + CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == 16'd0) begin
            state <= RUN;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        DRAIN: begin
          if (slot_free_s) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
